// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the ALU command, datapath mux selects and write enables.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [2:0]       alucont,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             funct_legal;
  logic             retire;

  assign funct_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                       (funct == FN_OR)  || (funct == FN_SLT);

  // Every instruction that reaches its final state leaves it for FETCH unconditionally.
  assign retire = (state_reg == MEMWB)   || (state_reg == MEMWR) || (state_reg == RTYPEWB) ||
                  (state_reg == BEQEX)   || (state_reg == ADDIWB) || (state_reg == JEX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYP:      state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = funct_legal ? RTYPEWB : FETCH;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  // While reset is held the outputs show FETCH, with every write enable suppressed.
  always_comb begin
    alucont  = 3'b010;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    case (reset ? FETCH : state_reg)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcen    = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          FN_SUB:  alucont = 3'b011;
          FN_AND:  alucont = 3'b000;
          FN_OR:   alucont = 3'b001;
          FN_SLT:  alucont = 3'b111;
          default: alucont = 3'b010;
        endcase
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        alucont = 3'b011;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign state   = state_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares state, packed control word and instret.
module tb_mc_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic [2:0]       alucont;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic             pcen;
  logic             iord;
  logic             irwrite;
  logic             memwrite;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucont(alucont), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Control word: {alucont, alusrca, alusrcb, pcsrc, pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg}
  localparam logic [14:0] C_FETCH   = 15'b010_0_01_00_1_0_1_0_0_0_0;
  localparam logic [14:0] C_FETCHR  = 15'b010_0_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_DECODE  = 15'b010_0_11_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMADR  = 15'b010_1_10_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMRD   = 15'b010_0_00_00_0_1_0_0_0_0_0;
  localparam logic [14:0] C_MEMWB   = 15'b010_0_00_00_0_0_0_0_1_0_1;
  localparam logic [14:0] C_MEMWR   = 15'b010_0_00_00_0_1_0_1_0_0_0;
  localparam logic [14:0] C_RTWB    = 15'b010_0_00_00_0_0_0_0_1_1_0;
  localparam logic [14:0] C_BEQ_Z1  = 15'b011_1_00_01_1_0_0_0_0_0_0;
  localparam logic [14:0] C_BEQ_Z0  = 15'b011_1_00_01_0_0_0_0_0_0_0;
  localparam logic [14:0] C_ADDIWB  = 15'b010_0_00_00_0_0_0_0_1_0_0;
  localparam logic [14:0] C_JEX     = 15'b010_0_00_10_1_0_0_0_0_0_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic [3:0]       st;
    logic [14:0]      ctrl;
    logic [CNT_W-1:0] inst;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               txn = 0;
  logic [CNT_W-1:0] exp_inst = '0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = sb.pop_front();
      act = {alucont, alusrca, alusrcb, pcsrc, pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg};
      checks += 3;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state txn=%0d got=%0d want=%0d", txn, state, e.st);
      end
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl txn=%0d state=%0d got=%b want=%b", txn, state, act, e.ctrl);
      end
      if (instret !== e.inst) begin
        errors++;
        $display("FAIL instret txn=%0d got=%0d want=%0d", txn, instret, e.inst);
      end
      $display("txn %0d: state=%0d ctrl=%b instret=%0d", txn, state, act, instret);
      txn++;
    end
  end

  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [3:0] es, input logic [14:0] ec);
    reset = r; op = o; funct = f; zero = z;
    sb.push_back('{st: es, ctrl: ec, inst: exp_inst});
    @(posedge clk); #1;
  endtask

  task automatic do_lw();
    cyc(0, LW, 6'd0, 0, 4'd0, C_FETCH);
    cyc(0, LW, 6'd0, 0, 4'd1, C_DECODE);
    cyc(0, LW, 6'd0, 0, 4'd2, C_MEMADR);
    cyc(0, LW, 6'd0, 0, 4'd3, C_MEMRD);
    cyc(0, LW, 6'd0, 0, 4'd4, C_MEMWB);
    exp_inst++;
  endtask

  task automatic do_sw();
    cyc(0, SW, 6'd0, 0, 4'd0, C_FETCH);
    cyc(0, SW, 6'd0, 0, 4'd1, C_DECODE);
    cyc(0, SW, 6'd0, 0, 4'd2, C_MEMADR);
    cyc(0, SW, 6'd0, 0, 4'd5, C_MEMWR);
    exp_inst++;
  endtask

  task automatic do_rtype(input logic [5:0] f, input logic [2:0] alu, input logic legal);
    cyc(0, RT, f, 0, 4'd0, C_FETCH);
    cyc(0, RT, f, 0, 4'd1, C_DECODE);
    cyc(0, RT, f, 0, 4'd6, {alu, 12'b1_00_00_0_0_0_0_0_0_0});
    if (legal) begin
      cyc(0, RT, f, 0, 4'd7, C_RTWB);
      exp_inst++;
    end
  endtask

  task automatic do_beq(input logic z);
    cyc(0, BEQ, 6'd0, z, 4'd0, C_FETCH);
    cyc(0, BEQ, 6'd0, z, 4'd1, C_DECODE);
    cyc(0, BEQ, 6'd0, z, 4'd8, z ? C_BEQ_Z1 : C_BEQ_Z0);
    exp_inst++;
  endtask

  task automatic do_addi();
    cyc(0, ADDI, 6'd0, 0, 4'd0, C_FETCH);
    cyc(0, ADDI, 6'd0, 0, 4'd1, C_DECODE);
    cyc(0, ADDI, 6'd0, 0, 4'd9, C_MEMADR);
    cyc(0, ADDI, 6'd0, 0, 4'd10, C_ADDIWB);
    exp_inst++;
  endtask

  task automatic do_j();
    cyc(0, JMP, 6'd0, 1, 4'd0, C_FETCH);
    cyc(0, JMP, 6'd0, 1, 4'd1, C_DECODE);
    cyc(0, JMP, 6'd0, 1, 4'd11, C_JEX);
    exp_inst++;
  endtask

  task automatic do_bad_op();
    cyc(0, BAD, 6'd0, 0, 4'd0, C_FETCH);
    cyc(0, BAD, 6'd0, 0, 4'd1, C_DECODE);
  endtask

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset for 2 cycles in the middle of a lw, sitting in MEMRD.
    reset = 1'b0;
    cyc(0, LW, 6'd0, 0, 4'd0, C_FETCH);
    cyc(0, LW, 6'd0, 0, 4'd1, C_DECODE);
    cyc(0, LW, 6'd0, 0, 4'd2, C_MEMADR);
    cyc(1, LW, 6'd0, 0, 4'd3, C_FETCHR);
    cyc(1, LW, 6'd0, 0, 4'd0, C_FETCHR);
    exp_inst = '0;

    do_lw();
    do_rtype(6'b101010, 3'b111, 1'b1);
    do_rtype(6'b100010, 3'b011, 1'b1);
    do_rtype(6'b100100, 3'b000, 1'b1);
    do_rtype(6'b100101, 3'b001, 1'b1);
    do_rtype(6'b100000, 3'b010, 1'b1);
    do_rtype(6'b111111, 3'b010, 1'b0);
    do_beq(1'b1);
    do_beq(1'b0);
    do_sw();
    do_j();
    do_bad_op();

    // Wraparound: reset, 15 retirements to all-ones, then one more.
    cyc(1, ADDI, 6'd0, 0, 4'd0, C_FETCHR);
    exp_inst = '0;
    for (int i = 0; i < 16; i++) do_addi();
    cyc(0, RT, 6'd0, 0, 4'd0, C_FETCH);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
